// File: rtl/dmem_pkg.sv
// Shared definitions for the dual-lane data-memory responder: FSM encodings,
// width derivations and the default data width.
package dmem_pkg;

  localparam int DEFAULT_DATA_W = 32;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_CONFLICT = 1'b1;

  // Bank select width; NUM_BANKS is expected to be a power of two >= 2.
  function automatic int bank_sel_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  function automatic int row_w(input int depth, input int num_banks);
    return ((depth / num_banks) > 1) ? $clog2(depth / num_banks) : 1;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Two-lane load/store request bus between the core (master) and the
// data-memory responder (slave).
interface dmem_responder_if
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = 32
);

  logic                  req1, we1;
  logic [ADDR_W-1:0]     addr1;
  logic [DATA_W-1:0]     wdata1;
  logic [DATA_W/8-1:0]   be1;
  logic                  req2, we2;
  logic [ADDR_W-1:0]     addr2;
  logic [DATA_W-1:0]     wdata2;
  logic [DATA_W/8-1:0]   be2;
  logic                  ready;
  logic                  rvalid1, rvalid2;
  logic [DATA_W-1:0]     rdata1, rdata2;
  logic                  err;

  modport master (
    output req1, we1, addr1, wdata1, be1,
    output req2, we2, addr2, wdata2, be2,
    input  ready, rvalid1, rdata1, rvalid2, rdata2, err
  );

  modport slave (
    input  req1, we1, addr1, wdata1, be1,
    input  req2, we2, addr2, wdata2, be2,
    output ready, rvalid1, rdata1, rvalid2, rdata2, err
  );

endinterface

// File: rtl/dmem_bank.sv
// Single-port word RAM bank with byte-enabled write and registered read.
module dmem_bank #(
  parameter int DATA_W = 32,
  parameter int ROWS   = 128,
  parameter int ROW_W  = 7
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [ROW_W-1:0]    row,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [ROWS];

  // NOTE: RAM arrays and their read register carry no reset so they map onto
  // block RAM; consumers gate the read data with their own reset valids.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < DATA_W / 8; i++) begin
          if (be[i]) mem[row][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[row];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Dual-lane data-memory responder: banked storage, same-bank conflict
// serialisation (lane 1 first) and registered per-lane read return.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 256,
  parameter int NUM_BANKS = 2
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus
);

  localparam int BANK_SEL_W = bank_sel_w(NUM_BANKS);
  localparam int ROW_W      = row_w(DEPTH, NUM_BANKS);
  localparam int ROWS       = DEPTH / NUM_BANKS;
  localparam int DEPTH_W    = $clog2(DEPTH);
  localparam int WORD_W     = ADDR_W - 2;
  localparam int BE_W       = DATA_W / 8;

  typedef struct packed {
    logic                  we;
    logic                  in_range;
    logic [BANK_SEL_W-1:0] bank;
    logic [ROW_W-1:0]      row;
    logic [DATA_W-1:0]     wdata;
    logic [BE_W-1:0]       be;
  } lane_op_t;

  function automatic lane_op_t decode(input logic we, input logic [WORD_W-1:0] word,
                                      input logic [DATA_W-1:0] wdata,
                                      input logic [BE_W-1:0] be);
    lane_op_t op;
    op.we       = we;
    op.in_range = (word >> DEPTH_W) == '0;
    op.bank     = word[BANK_SEL_W-1:0];
    op.row      = word[BANK_SEL_W +: ROW_W];
    op.wdata    = wdata;
    op.be       = be;
    return op;
  endfunction

  logic [0:0] state;
  lane_op_t   op1, op2, pend, svc2;
  logic       svc1_v, svc2_v, same_bank, same_word, shared_read, conflict;
  logic       rv1, rv2, oor1, oor2, err_q;
  logic [BANK_SEL_W-1:0] sel1, sel2;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{bus.addr1[1:0], bus.addr2[1:0]};

  // NOTE: every always_comb output is given a default before any branch so
  // no path leaves a value held, which would infer a latch.
  always_comb begin
    op1 = decode(bus.we1, bus.addr1[ADDR_W-1:2], bus.wdata1, bus.be1);
    op2 = decode(bus.we2, bus.addr2[ADDR_W-1:2], bus.wdata2, bus.be2);
    same_bank   = op1.in_range && op2.in_range && (op1.bank == op2.bank);
    same_word   = same_bank && (op1.row == op2.row);
    shared_read = same_word && !op1.we && !op2.we;
    conflict    = (state == ST_IDLE) && bus.req1 && bus.req2 && same_bank && !shared_read;
    svc1_v      = (state == ST_IDLE) && bus.req1;
    svc2_v      = 1'b0;
    svc2        = op2;
    if (state == ST_CONFLICT) begin
      svc2_v = 1'b1;
      svc2   = pend;
    end else begin
      svc2_v = bus.req2 && !conflict;
    end
  end

  logic [NUM_BANKS-1:0] b_en, b_we;
  logic [ROW_W-1:0]     b_row   [NUM_BANKS];
  logic [DATA_W-1:0]    b_wdata [NUM_BANKS];
  logic [DATA_W-1:0]    b_rdata [NUM_BANKS];
  logic [BE_W-1:0]      b_be    [NUM_BANKS];

  // Lane 1 is applied last; the two lanes only meet on one bank for a shared read.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      b_en[b]    = 1'b0;
      b_we[b]    = 1'b0;
      b_row[b]   = '0;
      b_wdata[b] = '0;
      b_be[b]    = '0;
      if (svc2_v && svc2.in_range && (svc2.bank == BANK_SEL_W'(b))) begin
        b_en[b]    = 1'b1;
        b_we[b]    = svc2.we;
        b_row[b]   = svc2.row;
        b_wdata[b] = svc2.wdata;
        b_be[b]    = svc2.be;
      end
      if (svc1_v && op1.in_range && (op1.bank == BANK_SEL_W'(b))) begin
        b_en[b]    = 1'b1;
        b_we[b]    = op1.we;
        b_row[b]   = op1.row;
        b_wdata[b] = op1.wdata;
        b_be[b]    = op1.be;
      end
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    dmem_bank #(
      .DATA_W (DATA_W),
      .ROWS   (ROWS),
      .ROW_W  (ROW_W)
    ) u_bank (
      .clk   (clk),
      .en    (b_en[g]),
      .we    (b_we[g]),
      .row   (b_row[g]),
      .wdata (b_wdata[g]),
      .be    (b_be[g]),
      .rdata (b_rdata[g])
    );
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      pend  <= '0;
      rv1   <= 1'b0;
      rv2   <= 1'b0;
      oor1  <= 1'b0;
      oor2  <= 1'b0;
      sel1  <= '0;
      sel2  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= conflict ? ST_CONFLICT : ST_IDLE;
      if (conflict) pend <= op2;
      rv1   <= svc1_v && !op1.we;
      rv2   <= svc2_v && !svc2.we;
      oor1  <= !op1.in_range;
      oor2  <= !svc2.in_range;
      sel1  <= op1.bank;
      sel2  <= svc2.bank;
      err_q <= (svc1_v && !op1.in_range) || (svc2_v && !svc2.in_range);
    end
  end

  assign bus.ready   = (state == ST_IDLE);
  assign bus.rvalid1 = rv1;
  assign bus.rvalid2 = rv2;
  assign bus.rdata1  = (rv1 && !oor1) ? b_rdata[sel1] : '0;
  assign bus.rdata2  = (rv2 && !oor2) ? b_rdata[sel2] : '0;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: single-cycle vector table plus
// hand-written conflict and reset sequences.
module tb_dmem_responder;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  dmem_responder #(
    .DATA_W    (32),
    .ADDR_W    (32),
    .DEPTH     (256),
    .NUM_BANKS (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic [3:0]  b1;
    logic        r2, w2;
    logic [31:0] a2, d2;
    logic [3:0]  b2;
    logic        e_rv1;
    logic [31:0] e_rd1;
    logic        e_rv2;
    logic [31:0] e_rd2;
    logic        e_err;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r1, input logic w1, input logic [31:0] a1,
                       input logic [31:0] d1, input logic [3:0] b1,
                       input logic r2, input logic w2, input logic [31:0] a2,
                       input logic [31:0] d2, input logic [3:0] b2);
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1; bus.be1 = b1;
    bus.req2 = r2; bus.we2 = w2; bus.addr2 = a2; bus.wdata2 = d2; bus.be2 = b2;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //            r1 w1 a1        d1            b1     r2 w2 a2        d2            b2     rv1 rd1           rv2 rd2           err
    vecs[0]  = '{0, 0, 32'h000, 32'h0,        4'h0, 0, 0, 32'h000, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0,        0};
    vecs[1]  = '{1, 1, 32'h000, 32'hDEADBEEF, 4'hF, 1, 1, 32'h004, 32'h12345678, 4'hF, 0, 32'h0,        0, 32'h0,        0};
    vecs[2]  = '{1, 1, 32'h008, 32'h0BADF00D, 4'hF, 1, 1, 32'h00C, 32'h11112222, 4'hF, 0, 32'h0,        0, 32'h0,        0};
    vecs[3]  = '{1, 1, 32'h010, 32'h0,        4'hF, 1, 1, 32'h014, 32'h0,        4'hF, 0, 32'h0,        0, 32'h0,        0};
    vecs[4]  = '{1, 0, 32'h000, 32'h0,        4'h0, 1, 0, 32'h004, 32'h0,        4'h0, 1, 32'hDEADBEEF, 1, 32'h12345678, 0};
    vecs[5]  = '{1, 0, 32'h004, 32'h0,        4'h0, 1, 0, 32'h000, 32'h0,        4'h0, 1, 32'h12345678, 1, 32'hDEADBEEF, 0};
    vecs[6]  = '{1, 0, 32'h008, 32'h0,        4'h0, 1, 0, 32'h008, 32'h0,        4'h0, 1, 32'h0BADF00D, 1, 32'h0BADF00D, 0};
    vecs[7]  = '{1, 0, 32'h400, 32'h0,        4'h0, 0, 0, 32'h000, 32'h0,        4'h0, 1, 32'h0,        0, 32'h0,        1};
    vecs[8]  = '{0, 0, 32'h000, 32'h0,        4'h0, 1, 1, 32'h400, 32'h55555555, 4'hF, 0, 32'h0,        0, 32'h0,        1};
    vecs[9]  = '{1, 1, 32'h000, 32'h0,        4'h0, 0, 0, 32'h008, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0,        0};
    vecs[10] = '{1, 0, 32'h000, 32'h0,        4'h0, 1, 0, 32'h404, 32'h0,        4'h0, 1, 32'hDEADBEEF, 1, 32'h0,        1};
    vecs[11] = '{1, 1, 32'h004, 32'hAABBCCDD, 4'h5, 1, 0, 32'h000, 32'h0,        4'h0, 0, 32'h0,        1, 32'hDEADBEEF, 0};
    vecs[12] = '{1, 0, 32'h004, 32'h0,        4'h0, 1, 0, 32'h008, 32'h0,        4'h0, 1, 32'h12BB56DD, 1, 32'h0BADF00D, 0};
    vecs[13] = '{1, 0, 32'h00C, 32'h0,        4'h0, 1, 1, 32'h000, 32'h0,        4'h0, 1, 32'h11112222, 0, 32'h0,        0};

    idle();
    @(negedge clk);
    check("reset ready", bus.ready, 1);
    check("reset rvalid1", bus.rvalid1, 0);
    check("reset rvalid2", bus.rvalid2, 0);
    check("reset rdata1", bus.rdata1, 0);
    check("reset err", bus.err, 0);
    reset = 1'b0;
    next_cycle();

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1, vecs[i].b1,
            vecs[i].r2, vecs[i].w2, vecs[i].a2, vecs[i].d2, vecs[i].b2);
      check($sformatf("v%0d ready_pre", i), bus.ready, 1);
      next_cycle();
      check($sformatf("v%0d ready_post", i), bus.ready, 1);
      check($sformatf("v%0d rvalid1", i), bus.rvalid1, vecs[i].e_rv1);
      check($sformatf("v%0d rvalid2", i), bus.rvalid2, vecs[i].e_rv2);
      check($sformatf("v%0d err", i), bus.err, vecs[i].e_err);
      if (vecs[i].e_rv1) check($sformatf("v%0d rdata1", i), bus.rdata1, vecs[i].e_rd1);
      if (vecs[i].e_rv2) check($sformatf("v%0d rdata2", i), bus.rdata2, vecs[i].e_rd2);
    end

    // Same-bank reads: lane 1 at +1, lane 2 at +2, inputs ignored while stalled.
    drive(1, 0, 32'h000, 32'h0, 4'h0, 1, 0, 32'h008, 32'h0, 4'h0);
    next_cycle();
    check("sb ready_low", bus.ready, 0);
    check("sb rvalid1", bus.rvalid1, 1);
    check("sb rdata1", bus.rdata1, 32'hDEADBEEF);
    check("sb rvalid2_early", bus.rvalid2, 0);
    drive(1, 0, 32'h004, 32'h0, 4'h0, 1, 0, 32'h00C, 32'h0, 4'h0);
    next_cycle();
    check("sb ready_back", bus.ready, 1);
    check("sb rvalid2", bus.rvalid2, 1);
    check("sb rdata2", bus.rdata2, 32'h0BADF00D);
    check("sb stalled_ignored", bus.rvalid1, 0);
    idle();
    next_cycle();
    check("sb quiet1", bus.rvalid1, 0);
    check("sb quiet2", bus.rvalid2, 0);

    // Lane-1 partial write then lane-2 read of the same word.
    drive(1, 1, 32'h010, 32'hAABBCCDD, 4'h3, 1, 0, 32'h010, 32'h0, 4'h0);
    next_cycle();
    check("wr ready_low", bus.ready, 0);
    check("wr rvalid2_early", bus.rvalid2, 0);
    idle();
    next_cycle();
    check("wr rvalid2", bus.rvalid2, 1);
    check("wr rdata2", bus.rdata2, 32'h0000CCDD);

    // Both lanes write one word: lane-2 bytes win on overlap.
    drive(1, 1, 32'h014, 32'h11111111, 4'hF, 1, 1, 32'h014, 32'h22222222, 4'h6);
    next_cycle();
    check("ww ready_low", bus.ready, 0);
    idle();
    next_cycle();
    check("ww ready_back", bus.ready, 1);
    drive(1, 0, 32'h014, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
    next_cycle();
    check("ww rdata1", bus.rdata1, 32'h11222211);

    // Reset during CONFLICT discards the pending lane-2 write.
    drive(1, 0, 32'h000, 32'h0, 4'h0, 1, 1, 32'h008, 32'hFFFFFFFF, 4'hF);
    next_cycle();
    check("rst in_conflict", bus.ready, 0);
    check("rst rvalid1_pre", bus.rvalid1, 1);
    reset = 1'b1;
    #1;
    check("rst ready_async", bus.ready, 1);
    check("rst rvalid1_async", bus.rvalid1, 0);
    check("rst rdata1_async", bus.rdata1, 0);
    check("rst err_async", bus.err, 0);
    idle();
    next_cycle();
    reset = 1'b0;
    next_cycle();
    drive(1, 0, 32'h008, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
    next_cycle();
    check("rst rvalid1_after", bus.rvalid1, 1);
    check("rst old_data", bus.rdata1, 32'h0BADF00D);
    idle();
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
